uart_cmd_ctrl: RTL

Packet-level command controller behind the UART receiver. It consumes the receiver's byte strobes and end-of-packet marker, parses framed command packets, and buffers payload bytes until the checksum is verified. Verified writes are committed to the glitch/EXI configuration register bank over a valid/ready byte port, and a one-cycle arm strobe is issued for the glitch engine. All other traffic is rejected with an error code and counters.

---
 rtl/uart_cmd_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// Packet-level command controller: parses SYNC/CMD/ADDR/LEN/DATA/CHK frames from the
// UART receiver, commits verified WRITE payloads to the register bank and pulses ARM.
module uart_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int          MAX_LEN   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_eop,
    output logic       reg_wr_valid,
    input  logic       reg_wr_ready,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       arm_pulse,
    output logic       busy,
    output logic [1:0] last_err,
    output logic [7:0] pkt_ok_cnt,
    output logic [7:0] pkt_err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_COMMIT
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_ARM   = 8'h02;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CHK   = 2'd1;
    localparam logic [1:0] ERR_TRUNC = 2'd2;
    localparam logic [1:0] ERR_CMD   = 2'd3;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic       is_write_q, is_write_d;
    logic [7:0] addr_q, addr_d;
    logic [3:0] len_q, len_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] chk_q, chk_d;
    logic [3:0] k_q, k_d;
    logic [7:0] buf_q [MAX_LEN];
    logic [7:0] buf_d [MAX_LEN];
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       arm_q, arm_d;
    logic [1:0] last_err_q, last_err_d;
    logic [7:0] ok_cnt_q, ok_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       byte_in;
    logic       parsing;
    logic       len_legal;
    logic [3:0] idx_next;
    logic [3:0] k_next;
    logic [7:0] next_byte;
    logic       err_hit;
    logic [1:0] err_code;
    logic       pkt_done;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        k_d        = k_q;
        buf_d      = buf_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        arm_d      = 1'b0;
        last_err_d = last_err_q;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_hit    = 1'b0;
        err_code   = ERR_NONE;
        pkt_done   = 1'b0;

        byte_in   = rx_ready && !rx_eop;
        parsing   = (state_q != ST_IDLE) && (state_q != ST_COMMIT);
        len_legal = is_write_q ? ((rx_data != 8'd0) && (rx_data <= MAX_LEN_B))
                               : (rx_data == 8'd0);
        idx_next  = idx_q + 4'd1;
        k_next    = k_q + 4'd1;

        // Payload byte that follows the one currently on the bus.
        next_byte = 8'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (k_next == 4'(i)) begin
                next_byte = buf_q[i];
            end
        end

        if (parsing && rx_eop) begin
            err_hit  = 1'b1;
            err_code = ERR_TRUNC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in && rx_data == SYNC_BYTE) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_in) begin
                        if (rx_data == CMD_WRITE || rx_data == CMD_ARM) begin
                            is_write_d = (rx_data == CMD_WRITE);
                            chk_d      = rx_data;
                            state_d    = ST_ADDR;
                        end else begin
                            err_hit  = 1'b1;
                            err_code = ERR_CMD;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_in) begin
                        addr_d  = rx_data;
                        chk_d   = chk_q ^ rx_data;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (byte_in) begin
                        if (len_legal) begin
                            len_d   = rx_data[3:0];
                            idx_d   = 4'd0;
                            chk_d   = chk_q ^ rx_data;
                            state_d = (rx_data == 8'd0) ? ST_CHK : ST_DATA;
                        end else begin
                            err_hit  = 1'b1;
                            err_code = ERR_CMD;
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_in) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx_q == 4'(i)) begin
                                buf_d[i] = rx_data;
                            end
                        end
                        chk_d = chk_q ^ rx_data;
                        idx_d = idx_next;
                        if (idx_next == len_q) begin
                            state_d = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (byte_in) begin
                        if (rx_data != chk_q) begin
                            err_hit  = 1'b1;
                            err_code = ERR_CHK;
                        end else if (is_write_q) begin
                            // Bus is loaded only here, so a bad packet never reaches the bank.
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = buf_q[0];
                            k_d        = 4'd0;
                            state_d    = ST_COMMIT;
                        end else begin
                            arm_d    = 1'b1;
                            pkt_done = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (wr_valid_q && reg_wr_ready) begin
                        if (k_q == len_q - 4'd1) begin
                            wr_valid_d = 1'b0;
                            pkt_done   = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            k_d       = k_next;
                            wr_addr_d = addr_q + {4'b0000, k_next};
                            wr_data_d = next_byte;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (pkt_done) begin
            ok_cnt_d   = sat_inc(ok_cnt_q);
            last_err_d = ERR_NONE;
        end
        if (err_hit) begin
            last_err_d = err_code;
            err_cnt_d  = sat_inc(err_cnt_q);
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= 8'd0;
            len_q      <= 4'd0;
            idx_q      <= 4'd0;
            chk_q      <= 8'd0;
            k_q        <= 4'd0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            arm_q      <= 1'b0;
            last_err_q <= ERR_NONE;
            ok_cnt_q   <= 8'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            k_q        <= k_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            arm_q      <= arm_d;
            last_err_q <= last_err_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Payload storage carries no reset; it is always rewritten before being read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign reg_wr_valid = wr_valid_q;
    assign reg_addr     = wr_addr_q;
    assign reg_wdata    = wr_data_q;
    assign arm_pulse    = arm_q;
    assign busy         = (state_q != ST_IDLE);
    assign last_err     = last_err_q;
    assign pkt_ok_cnt   = ok_cnt_q;
    assign pkt_err_cnt  = err_cnt_q;

endmodule
